// File: rtl/ram_lsu_pkg.sv
// Shared definitions for the RAM load/store sequencer: funct3 encodings,
// FSM states and access-size / legality helpers.
package ram_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    // Access size in bytes; funct3[2] only selects the extension mode.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
        if (we)
            return funct3[2] || (funct3[1:0] == 2'b11);
        return (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    endfunction

    function automatic logic crosses(input logic [1:0] offset, input logic [2:0] funct3);
        return ({1'b0, offset} + size_of(funct3)) > 3'd4;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte masks, lane-shifted store data, and load
// extraction with sign/zero extension over a two-word window.
module lsu_align
    import ram_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    output logic [7:0]  mask,
    output logic [63:0] wide_wdata,
    output logic [31:0] load_data
);

    logic [3:0]  base;
    logic [4:0]  sh;
    logic [63:0] pair;
    logic [31:0] win;

    always_comb begin
        sh = {offset, 3'b000};
        case (size_of(funct3))
            3'd1:    base = 4'b0001;
            3'd2:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
        mask       = {4'b0000, base} << offset;
        wide_wdata = {32'h0, wdata} << sh;
        pair       = {hi_word, lo_word};
        win        = pair[sh +: 32];
        case (funct3[1:0])
            2'd0:    load_data = funct3[2] ? {24'h0, win[7:0]} : {{24{win[7]}}, win[7:0]};
            2'd1:    load_data = funct3[2] ? {16'h0, win[15:0]} : {{16{win[15]}}, win[15:0]};
            default: load_data = win;
        endcase
    end

endmodule

// File: rtl/ram_lsu.sv
// Load/store sequencer: turns byte-addressed RV32I accesses into one or two
// word accesses on the RAM ports, with a valid/ready request handshake.
module ram_lsu
    import ram_lsu_pkg::*;
#(
    parameter bit MISALIGN_EN = 1'b1,
    parameter int WADDR_W     = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic               resp_err,
    output logic [31:0]        resp_rdata,
    output logic [WADDR_W-1:0] mem_addr,
    input  logic [31:0]        mem_rdata,
    output logic               mem_we,
    output logic [31:0]        mem_wdata,
    output logic [3:0]         mem_byte_en
);

    // Handshake: a request transfers on a posedge where req_valid && req_ready;
    // req_ready is high only in IDLE, and resp_valid pulses for one cycle in RESP.
    state_t             state, state_nxt;
    logic               we_q, err_q;
    logic [2:0]         f3_q;
    logic [1:0]         off_q;
    logic [31:0]        wdata_q, buf0, buf1;
    logic [WADDR_W-1:0] addr_q;
    logic               bad_req, cross_q;
    logic [7:0]         mask;
    logic [63:0]        wide_wdata;
    logic [31:0]        load_data;

    assign bad_req = f3_illegal(req_we, req_funct3) ||
                     (!MISALIGN_EN && crosses(req_addr[1:0], req_funct3));
    assign cross_q = MISALIGN_EN && crosses(off_q, f3_q);

    lsu_align u_align (
        .funct3     (f3_q),
        .offset     (off_q),
        .wdata      (wdata_q),
        .lo_word    (buf0),
        .hi_word    (buf1),
        .mask       (mask),
        .wide_wdata (wide_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            wdata_q <= 32'h0;
            buf0    <= 32'h0;
            buf1    <= 32'h0;
            addr_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    f3_q    <= req_funct3;
                    off_q   <= req_addr[1:0];
                    wdata_q <= req_wdata;
                    err_q   <= bad_req;
                    buf0    <= 32'h0;
                    buf1    <= 32'h0;
                    // Rejected requests never touch RAM, so mem_addr keeps its value.
                    if (!bad_req)
                        addr_q <= req_addr[WADDR_W+1:2];
                end
                ACC0: begin
                    if (!we_q)
                        buf0 <= mem_rdata;
                    if (cross_q)
                        addr_q <= addr_q + 1'b1;
                end
                ACC1: if (!we_q) buf1 <= mem_rdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = bad_req ? RESP : ACC0;
            ACC0: state_nxt = cross_q ? ACC1 : RESP;
            ACC1: state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state == IDLE);
        resp_valid  = (state == RESP);
        resp_err    = (state == RESP) && err_q;
        resp_rdata  = 32'h0;
        mem_addr    = addr_q;
        mem_we      = 1'b0;
        mem_wdata   = 32'h0;
        mem_byte_en = 4'h0;
        if (state == RESP && !we_q && !err_q)
            resp_rdata = load_data;
        if (we_q && state == ACC0) begin
            mem_we      = 1'b1;
            mem_wdata   = wide_wdata[31:0];
            mem_byte_en = mask[3:0];
        end
        if (we_q && state == ACC1) begin
            mem_we      = 1'b1;
            mem_wdata   = wide_wdata[63:32];
            mem_byte_en = mask[7:4];
        end
    end

endmodule

// File: tb/tb_ram_lsu.sv
// Directed bench for ram_lsu: one instance with misaligned splitting, one
// that rejects word-crossing accesses, and a byte-enabled RAM model.
module tb_ram_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_a, req_valid_b;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_we;
    logic [31:0] a_resp_rdata, a_mem_rdata, a_mem_wdata;
    logic [29:0] a_mem_addr;
    logic [3:0]  a_mem_byte_en;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_we;
    logic [31:0] b_resp_rdata, b_mem_rdata, b_mem_wdata;
    logic [29:0] b_mem_addr;
    logic [3:0]  b_mem_byte_en;

    logic [31:0] ram [0:65535];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_lsu #(.MISALIGN_EN(1'b1), .WADDR_W(30)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(a_req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(a_resp_valid), .resp_err(a_resp_err), .resp_rdata(a_resp_rdata),
        .mem_addr(a_mem_addr), .mem_rdata(a_mem_rdata), .mem_we(a_mem_we),
        .mem_wdata(a_mem_wdata), .mem_byte_en(a_mem_byte_en)
    );

    ram_lsu #(.MISALIGN_EN(1'b0), .WADDR_W(30)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(b_req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(b_resp_valid), .resp_err(b_resp_err), .resp_rdata(b_resp_rdata),
        .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata), .mem_we(b_mem_we),
        .mem_wdata(b_mem_wdata), .mem_byte_en(b_mem_byte_en)
    );

    assign a_mem_rdata = ram[a_mem_addr[15:0]];
    assign b_mem_rdata = 32'h0;

    always @(posedge clk) begin
        if (a_mem_we)
            for (int b = 0; b < 4; b++)
                if (a_mem_byte_en[b])
                    ram[a_mem_addr[15:0]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
    end

    // Observation mux: which instance the current request targets.
    logic        sel_b;
    logic        o_ready, o_resp_valid, o_resp_err, o_mem_we;
    logic [31:0] o_resp_rdata, o_mem_wdata;
    logic [29:0] o_mem_addr;
    logic [3:0]  o_byte_en;
    assign o_ready      = sel_b ? b_req_ready   : a_req_ready;
    assign o_resp_valid = sel_b ? b_resp_valid  : a_resp_valid;
    assign o_resp_err   = sel_b ? b_resp_err    : a_resp_err;
    assign o_resp_rdata = sel_b ? b_resp_rdata  : a_resp_rdata;
    assign o_mem_we     = sel_b ? b_mem_we      : a_mem_we;
    assign o_mem_wdata  = sel_b ? b_mem_wdata   : a_mem_wdata;
    assign o_mem_addr   = sel_b ? b_mem_addr    : a_mem_addr;
    assign o_byte_en    = sel_b ? b_mem_byte_en : a_mem_byte_en;

    // Per-request trace filled by run_req.
    int          lat, nw;
    logic        got, rdy;
    logic [31:0] r_err, r_data;
    logic [31:0] cyc_addr [0:7];
    logic [31:0] w_addr [0:7];
    logic [31:0] w_be [0:7];
    logic [31:0] w_data [0:7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        sel_b      = sel;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        #1 rdy = o_ready;
        @(posedge clk);
        #1 req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    // Issues one request and records per-cycle mem_addr, writes and the response.
    task automatic run_req(input logic sel, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        drive(sel, we, f3, addr, wdata);
        lat = 0; nw = 0; got = 1'b0; r_err = 32'hx; r_data = 32'hx;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            lat++;
            cyc_addr[i] = {2'b00, o_mem_addr};
            if (o_mem_we) begin
                w_addr[nw] = {2'b00, o_mem_addr};
                w_be[nw]   = {28'h0, o_byte_en};
                w_data[nw] = o_mem_wdata;
                nw++;
            end
            if (o_resp_valid) begin
                got    = 1'b1;
                r_err  = {31'h0, o_resp_err};
                r_data = o_resp_rdata;
            end
        end
        check("accept_ready", {31'h0, rdy}, 32'h1);
        check("resp_seen", {31'h0, got}, 32'h1);
    endtask

    logic saw_resp;

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 32'h0;
        ram[16'hFFFF] = 32'hAB000000;
        ram[16'h0000] = 32'h000000CD;
        sel_b = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'h0, a_req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, a_resp_valid}, 32'h0);
        check("rst_mem_we", {31'h0, a_mem_we}, 32'h0);
        check("rst_mem_addr", {2'b00, a_mem_addr}, 32'h0);
        check("rst_byte_en", {28'h0, a_mem_byte_en}, 32'h0);
        check("rst_rdata", a_resp_rdata, 32'h0);
        rst = 1'b0;

        // SW 0xDEADBEEF to 0x1C000
        run_req(1'b0, 1'b1, 3'd2, 32'h0001C000, 32'hDEADBEEF);
        check("sw_lat", lat, 2);
        check("sw_err", r_err, 32'h0);
        check("sw_rdata", r_data, 32'h0);
        check("sw_nw", nw, 1);
        check("sw_addr", w_addr[0], 32'h7000);
        check("sw_be", w_be[0], 32'hF);
        check("sw_wdata", w_data[0], 32'hDEADBEEF);

        // SH 0xC0DE to 0x1C000
        run_req(1'b0, 1'b1, 3'd1, 32'h0001C000, 32'h0000C0DE);
        check("sh_nw", nw, 1);
        check("sh_be", w_be[0], 32'h3);
        check("sh_wdata", w_data[0], 32'h0000C0DE);

        run_req(1'b0, 1'b0, 3'd2, 32'h0001C000, 32'h0);
        check("lw_data", r_data, 32'hDEADC0DE);
        check("lw_lat", lat, 2);
        check("lw_nw", nw, 0);
        run_req(1'b0, 1'b0, 3'd0, 32'h0001C003, 32'h0);
        check("lb_data", r_data, 32'hFFFFFFDE);
        run_req(1'b0, 1'b0, 3'd4, 32'h0001C003, 32'h0);
        check("lbu_data", r_data, 32'h000000DE);
        run_req(1'b0, 1'b0, 3'd1, 32'h0001C002, 32'h0);
        check("lh_data", r_data, 32'hFFFFDEAD);
        run_req(1'b0, 1'b0, 3'd5, 32'h0001C002, 32'h0);
        check("lhu_data", r_data, 32'h0000DEAD);

        // Misaligned SW split across words 0x7000 and 0x7001
        run_req(1'b0, 1'b1, 3'd2, 32'h0001C002, 32'h11223344);
        check("msw_lat", lat, 3);
        check("msw_nw", nw, 2);
        check("msw_addr0", w_addr[0], 32'h7000);
        check("msw_be0", w_be[0], 32'hC);
        check("msw_wdata0", w_data[0], 32'h33440000);
        check("msw_addr1", w_addr[1], 32'h7001);
        check("msw_be1", w_be[1], 32'h3);
        check("msw_wdata1", w_data[1], 32'h00001122);
        check("msw_err", r_err, 32'h0);

        run_req(1'b0, 1'b0, 3'd2, 32'h0001C002, 32'h0);
        check("mlw_data", r_data, 32'h11223344);
        check("mlw_lat", lat, 3);

        // LH at top of address space wraps to word 0
        run_req(1'b0, 1'b0, 3'd1, 32'hFFFFFFFF, 32'h0);
        check("wrap_addr0", cyc_addr[0], 32'h3FFFFFFF);
        check("wrap_addr1", cyc_addr[1], 32'h00000000);
        check("wrap_data", r_data, 32'hFFFFCDAB);
        check("wrap_lat", lat, 3);

        // Illegal funct3
        run_req(1'b0, 1'b0, 3'd3, 32'h0001C000, 32'h0);
        check("ill_ld_err", r_err, 32'h1);
        check("ill_ld_lat", lat, 1);
        check("ill_ld_nw", nw, 0);
        check("ill_ld_rdata", r_data, 32'h0);
        run_req(1'b0, 1'b1, 3'd4, 32'h0001C000, 32'hFFFFFFFF);
        check("ill_st_err", r_err, 32'h1);
        check("ill_st_nw", nw, 0);

        // Splitting disabled: crossing store rejected
        run_req(1'b1, 1'b1, 3'd2, 32'h0001C002, 32'h11223344);
        check("nomis_err", r_err, 32'h1);
        check("nomis_lat", lat, 1);
        check("nomis_nw", nw, 0);
        run_req(1'b1, 1'b0, 3'd2, 32'h0001C000, 32'h0);
        check("nomis_aligned_err", r_err, 32'h0);
        check("nomis_aligned_lat", lat, 2);

        // Reset during ACC1 of a misaligned store
        drive(1'b0, 1'b1, 3'd2, 32'h0001C002, 32'h55667788);
        @(negedge clk);
        check("rmid_acc0_we", {31'h0, a_mem_we}, 32'h1);
        check("rmid_acc0_be", {28'h0, a_mem_byte_en}, 32'hC);
        @(negedge clk);
        check("rmid_acc1_addr", {2'b00, a_mem_addr}, 32'h7001);
        check("rmid_acc1_we", {31'h0, a_mem_we}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check("rmid_ready", {31'h0, a_req_ready}, 32'h1);
        check("rmid_we", {31'h0, a_mem_we}, 32'h0);
        check("rmid_be", {28'h0, a_mem_byte_en}, 32'h0);
        check("rmid_wdata", a_mem_wdata, 32'h0);
        check("rmid_addr", {2'b00, a_mem_addr}, 32'h0);
        check("rmid_resp_err", {31'h0, a_resp_err}, 32'h0);
        saw_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a_resp_valid) saw_resp = 1'b1;
            if (i == 1) rst = 1'b0;
        end
        check("rmid_no_resp", {31'h0, saw_resp}, 32'h0);
        check("rmid_word0", ram[16'h7000], 32'h7788C0DE);
        check("rmid_word1", ram[16'h7001], 32'h00001122);

        run_req(1'b0, 1'b0, 3'd2, 32'h0001C000, 32'h0);
        check("post_rst_lw", r_data, 32'h7788C0DE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
